// File: rtl/clock_pkg.sv
// Shared alarm FSM state encoding and time-of-day limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } alarm_state_t;

   localparam logic [5:0] MAX_MIN     = 6'd59;
   localparam logic [5:0] MAX_HOUR    = 6'd23;
   localparam int         SEC_PER_MIN = 60;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced level button.
// Latency: pulse is combinational off the stored history; consumers act on the next clk.
// Backpressure: none; history resets to 1 so a button held through reset never fires.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic btn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_q <= 1'b1;
      else        btn_q <= btn;
   end

   assign rise = btn & ~btn_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: alarm time edit, arm/ring/snooze FSM and buzzer blink.
// Latency: button edges and the match trigger take effect on the next clk.
// Backpressure: none; a state-leaving button wins over a coincident tick_1s.
module alarm_controller
   import clock_pkg::*;
#(
   parameter int SNOOZE_MIN     = 5,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1s,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic       set_en,
   input  logic       pos,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_arm,
   input  logic       btn_snooze,
   input  logic       btn_dismiss,
   output logic [5:0] alarm_hour,
   output logic [5:0] alarm_min,
   output logic       armed,
   output logic       ringing,
   output logic       snoozing,
   output logic       buzzer
);

   localparam logic [7:0]  RING_LAST   = 8'(RING_TIMEOUT_S - 1);
   localparam logic [10:0] SNOOZE_LOAD = 11'(SNOOZE_MIN * SEC_PER_MIN);

   logic up_e, down_e, arm_e, snz_e, dis_e;

   btn_edge u_up  (.clk(clk), .rst_n(rst_n), .btn(btn_up),      .rise(up_e));
   btn_edge u_dn  (.clk(clk), .rst_n(rst_n), .btn(btn_down),    .rise(down_e));
   btn_edge u_arm (.clk(clk), .rst_n(rst_n), .btn(btn_arm),     .rise(arm_e));
   btn_edge u_snz (.clk(clk), .rst_n(rst_n), .btn(btn_snooze),  .rise(snz_e));
   btn_edge u_dis (.clk(clk), .rst_n(rst_n), .btn(btn_dismiss), .rise(dis_e));

   alarm_state_t state;
   logic [7:0]   ring_cnt;
   logic [10:0]  snooze_cnt;
   logic         blink;
   logic         match_q;
   logic         match;
   logic         trigger;
   logic         edit_ok;
   logic         inc;
   logic         dec;

   assign edit_ok = set_en && (state == DISARMED || state == ARMED);
   assign inc     = up_e & ~down_e;
   assign dec     = down_e & ~up_e;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_hour <= 6'd0;
         alarm_min  <= 6'd0;
      end else if (edit_ok) begin
         if (!pos) begin
            if (inc)      alarm_min <= (alarm_min == MAX_MIN) ? 6'd0 : alarm_min + 6'd1;
            else if (dec) alarm_min <= (alarm_min == 6'd0) ? MAX_MIN : alarm_min - 6'd1;
         end else begin
            if (inc)      alarm_hour <= (alarm_hour == MAX_HOUR) ? 6'd0 : alarm_hour + 6'd1;
            else if (dec) alarm_hour <= (alarm_hour == 6'd0) ? MAX_HOUR : alarm_hour - 6'd1;
         end
      end
   end

   // match_q tracks even while editing, so a match created by an edit never fires later
   assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
   assign trigger = match & ~match_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= DISARMED;
         ring_cnt   <= 8'd0;
         snooze_cnt <= 11'd0;
         blink      <= 1'b0;
         match_q    <= 1'b1;
      end else begin
         match_q <= match;
         case (state)
            DISARMED: begin
               if (arm_e) state <= ARMED;
            end
            ARMED: begin
               if (arm_e) begin
                  state <= DISARMED;
               end else if (trigger && !set_en) begin
                  state    <= RINGING;
                  ring_cnt <= 8'd0;
                  blink    <= 1'b1;
               end
            end
            RINGING: begin
               if (arm_e) begin
                  state <= DISARMED;
               end else if (dis_e) begin
                  state <= ARMED;
               end else if (snz_e) begin
                  state      <= SNOOZE;
                  snooze_cnt <= SNOOZE_LOAD;
               end else if (tick_1s) begin
                  if (ring_cnt == RING_LAST) state <= ARMED;
                  ring_cnt <= ring_cnt + 8'd1;
                  blink    <= ~blink;
               end
            end
            SNOOZE: begin
               if (arm_e) begin
                  state <= DISARMED;
               end else if (dis_e) begin
                  state <= ARMED;
               end else if (tick_1s) begin
                  if (snooze_cnt <= 11'd1) begin
                     state      <= RINGING;
                     snooze_cnt <= 11'd0;
                     ring_cnt   <= 8'd0;
                     blink      <= 1'b1;
                  end else begin
                     snooze_cnt <= snooze_cnt - 11'd1;
                  end
               end
            end
            default: state <= DISARMED;
         endcase
      end
   end

   assign armed    = (state != DISARMED);
   assign ringing  = (state == RINGING);
   assign snoozing = (state == SNOOZE);
   assign buzzer   = ringing & blink;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with SNOOZE_MIN=1, RING_TIMEOUT_S=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1s;
   logic [5:0] cur_hour, cur_min, cur_sec;
   logic       set_en, pos;
   logic       btn_up, btn_down, btn_arm, btn_snooze, btn_dismiss;
   logic [5:0] alarm_hour, alarm_min;
   logic       armed, ringing, snoozing, buzzer;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alarm_controller #(.SNOOZE_MIN(1), .RING_TIMEOUT_S(3)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .set_en(set_en), .pos(pos),
      .btn_up(btn_up), .btn_down(btn_down), .btn_arm(btn_arm),
      .btn_snooze(btn_snooze), .btn_dismiss(btn_dismiss),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
   );

   typedef struct {
      logic       se, ps, up, dn, arm, snz, dis;
      logic [5:0] hr, mn;
      logic       e_armed, e_ring, e_snzg, e_buz;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(input logic se, ps, up, dn, arm, snz, dis,
                               input logic [5:0] hr, mn, input logic ea);
      vec_t v;
      v.se = se; v.ps = ps; v.up = up; v.dn = dn; v.arm = arm; v.snz = snz; v.dis = dis;
      v.hr = hr; v.mn = mn; v.e_armed = ea; v.e_ring = 1'b0; v.e_snzg = 1'b0; v.e_buz = 1'b0;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      tick_1s = 1'b1; step();
      tick_1s = 1'b0; step();
   endtask

   task automatic press_up(input int n);
      for (int i = 0; i < n; i++) begin
         btn_up = 1'b1; step();
         btn_up = 1'b0; step();
      end
   endtask

   task automatic press_arm();
      btn_arm = 1'b1; step();
      btn_arm = 1'b0; step();
   endtask

   task automatic retrigger(input string nm);
      cur_sec = 6'd1; step();
      cur_sec = 6'd0; step();
      chk(nm, ringing, 1);
   endtask

   initial begin
      // se ps up dn arm snz dis  hour min armed
      tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0,  0, 59, 0);  // 0 -> 59 wrap
      tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 59, 0);
      tbl[2]  = mk(1, 0, 1, 0, 0, 0, 0,  0,  0, 0);  // 59 -> 0 wrap
      tbl[3]  = mk(1, 0, 1, 0, 0, 0, 0,  0,  0, 0);  // held level: no repeat
      tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 0);
      tbl[5]  = mk(1, 1, 0, 1, 0, 0, 0, 23,  0, 0);  // hour 0 -> 23 wrap
      tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0, 23,  0, 0);
      tbl[7]  = mk(1, 1, 1, 0, 0, 0, 0,  0,  0, 0);  // hour 23 -> 0 wrap
      tbl[8]  = mk(1, 1, 0, 0, 0, 0, 0,  0,  0, 0);
      tbl[9]  = mk(1, 0, 1, 1, 0, 0, 0,  0,  0, 0);  // up+down cancels
      tbl[10] = mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 0);
      tbl[11] = mk(0, 0, 1, 0, 0, 0, 0,  0,  0, 0);  // set_en low: no edit
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0,  0, 0);
      tbl[13] = mk(1, 0, 1, 0, 0, 0, 0,  0,  1, 0);
      tbl[14] = mk(1, 0, 0, 0, 0, 0, 0,  0,  1, 0);
      tbl[15] = mk(0, 0, 0, 0, 1, 0, 0,  0,  1, 1);  // arm
      tbl[16] = mk(0, 0, 0, 0, 1, 0, 0,  0,  1, 1);  // held arm: no toggle
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  0,  1, 1);
      tbl[18] = mk(1, 0, 1, 0, 0, 0, 0,  0,  2, 1);  // edit while armed
      tbl[19] = mk(1, 0, 0, 0, 0, 0, 0,  0,  2, 1);
      tbl[20] = mk(0, 0, 0, 0, 1, 0, 0,  0,  2, 0);  // disarm
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,  0,  2, 0);

      rst_n = 1'b0; tick_1s = 1'b0; set_en = 1'b0; pos = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_arm = 1'b0; btn_snooze = 1'b0; btn_dismiss = 1'b0;
      cur_hour = 6'd12; cur_min = 6'd0; cur_sec = 6'd10;
      #12;
      chk("rst_armed", armed, 0);
      chk("rst_ringing", ringing, 0);
      chk("rst_snoozing", snoozing, 0);
      chk("rst_buzzer", buzzer, 0);
      chk("rst_alarm_hour", alarm_hour, 0);
      chk("rst_alarm_min", alarm_min, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_armed", armed, 0);

      for (int i = 0; i < 22; i++) begin
         set_en = tbl[i].se; pos = tbl[i].ps;
         btn_up = tbl[i].up; btn_down = tbl[i].dn; btn_arm = tbl[i].arm;
         btn_snooze = tbl[i].snz; btn_dismiss = tbl[i].dis;
         step();
         chk($sformatf("vec%0d_hour", i), alarm_hour, tbl[i].hr);
         chk($sformatf("vec%0d_min", i), alarm_min, tbl[i].mn);
         chk($sformatf("vec%0d_armed", i), armed, tbl[i].e_armed);
         chk($sformatf("vec%0d_ringing", i), ringing, tbl[i].e_ring);
         chk($sformatf("vec%0d_snoozing", i), snoozing, tbl[i].e_snzg);
         chk($sformatf("vec%0d_buzzer", i), buzzer, tbl[i].e_buz);
      end

      // alarm 00:02 -> 06:30
      set_en = 1'b1; pos = 1'b0; press_up(28);
      pos = 1'b1; press_up(6);
      chk("set_hour", alarm_hour, 6);
      chk("set_min", alarm_min, 30);
      set_en = 1'b0; pos = 1'b0;
      press_arm();
      chk("armed_for_trigger", armed, 1);

      cur_hour = 6'd6; cur_min = 6'd29; cur_sec = 6'd59;
      step();
      chk("pre_match_ringing", ringing, 0);
      cur_min = 6'd30; cur_sec = 6'd0;
      begin
         int w = 0;
         while (!ringing && w < 2) begin step(); w++; end
      end
      chk("trigger_ringing", ringing, 1);
      chk("trigger_buzzer", buzzer, 1);

      tick();
      chk("tick1_buzzer_off", buzzer, 0);
      chk("tick1_ringing", ringing, 1);
      tick();
      chk("tick2_buzzer_on", buzzer, 1);
      tick();
      chk("timeout_ringing", ringing, 0);
      chk("timeout_armed", armed, 1);
      chk("timeout_buzzer", buzzer, 0);
      step(); step(); step();
      chk("no_retrigger", ringing, 0);

      retrigger("snz_pre_ring");
      btn_snooze = 1'b1; step();
      chk("snooze_snoozing", snoozing, 1);
      chk("snooze_ringing", ringing, 0);
      chk("snooze_buzzer", buzzer, 0);
      btn_snooze = 1'b0; step();
      for (int i = 0; i < 59; i++) tick();
      chk("snooze_59_snoozing", snoozing, 1);
      tick();
      chk("snooze_60_ringing", ringing, 1);
      chk("snooze_60_buzzer", buzzer, 1);
      chk("snooze_60_snoozing", snoozing, 0);

      btn_snooze = 1'b1; btn_dismiss = 1'b1; step();
      chk("snz_dis_armed", armed, 1);
      chk("snz_dis_ringing", ringing, 0);
      chk("snz_dis_snoozing", snoozing, 0);
      btn_snooze = 1'b0; btn_dismiss = 1'b0; step();

      retrigger("arm_dis_pre_ring");
      btn_arm = 1'b1; btn_dismiss = 1'b1; step();
      chk("arm_dis_armed", armed, 0);
      chk("arm_dis_ringing", ringing, 0);
      btn_arm = 1'b0; btn_dismiss = 1'b0; step();

      press_arm();
      retrigger("dis_snz_pre_ring");
      btn_snooze = 1'b1; step();
      btn_snooze = 1'b0; step();
      btn_dismiss = 1'b1; tick_1s = 1'b1; step();
      chk("dis_in_snooze_armed", armed, 1);
      chk("dis_in_snooze_snoozing", snoozing, 0);
      chk("dis_in_snooze_ringing", ringing, 0);
      btn_dismiss = 1'b0; tick_1s = 1'b0; step();

      retrigger("rst_pre_ring");
      chk("rst_pre_buzzer", buzzer, 1);
      rst_n = 1'b0;
      #2;
      chk("async_rst_buzzer", buzzer, 0);
      chk("async_rst_ringing", ringing, 0);
      chk("async_rst_armed", armed, 0);
      chk("async_rst_snoozing", snoozing, 0);
      chk("async_rst_hour", alarm_hour, 0);
      chk("async_rst_min", alarm_min, 0);
      cur_hour = 6'd0; cur_min = 6'd0; cur_sec = 6'd0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rel_hour", alarm_hour, 0);
      chk("rel_min", alarm_min, 0);
      chk("rel_armed", armed, 0);
      chk("rel_ringing", ringing, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 The block SHALL have parameter SNOOZE_MIN, default 5, giving the snooze length in minutes (1..30).
REQ-002 The block SHALL have parameter RING_TIMEOUT_S, default 60, giving the auto-stop time for ringing in seconds (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-005 The block SHALL have port tick_1s, input, 1 bit: a one-cycle pulse from the clock datapath each second.
REQ-006 The block SHALL have ports cur_hour, cur_min and cur_sec, input, 6 bits each: the current binary time from the clock datapath.
REQ-007 The block SHALL have ports set_en and pos, input, 1 bit each: set_en enables alarm edit; pos selects the field (0 = minute, 1 = hour).
REQ-008 The block SHALL have ports btn_up, btn_down, btn_arm, btn_snooze and btn_dismiss, input, 1 bit each: debounced level buttons.
REQ-009 The block SHALL have ports alarm_hour and alarm_min, output, 6 bits each: the stored alarm time.
REQ-010 The block SHALL have ports armed, ringing, snoozing and buzzer, output, 1 bit each: status flags and the buzzer drive.

Function
REQ-011 Every button SHALL act only on its rising edge, detected one cycle after the input rises.
REQ-012 The FSM SHALL have four states: DISARMED, ARMED, RINGING and SNOOZE; armed/ringing/snoozing SHALL be 1 exactly in ARMED-or-later/RINGING/SNOOZE respectively (armed = state != DISARMED).
REQ-013 Edit SHALL apply only in DISARMED or ARMED with set_en=1: up/down changes alarm_min (wrapping 59->0 and 0->59) when pos=0, or alarm_hour (wrapping 23->0 and 0->23) when pos=1; simultaneous up and down SHALL do nothing.
REQ-014 The btn_arm edge SHALL toggle DISARMED<->ARMED, and from RINGING or SNOOZE SHALL go to DISARMED.
REQ-015 The match signal SHALL be cur_hour==alarm_hour && cur_min==alarm_min && cur_sec==0; the trigger SHALL be the match rising edge (registered previous value), taken ARMED->RINGING on the next clk provided set_en=0.
REQ-016 In RINGING, ring_cnt SHALL count tick_1s; when it reaches RING_TIMEOUT_S the state SHALL go to ARMED.
REQ-017 In RINGING, a btn_dismiss edge SHALL go to ARMED; a btn_snooze edge SHALL go to SNOOZE, loading snooze_cnt with SNOOZE_MIN*60.
REQ-018 Simultaneous dismiss and snooze SHALL resolve as dismiss; btn_arm SHALL have priority over both.
REQ-019 In SNOOZE, snooze_cnt SHALL decrement on tick_1s; at 0 the state SHALL go to RINGING with ring_cnt cleared, and a btn_dismiss edge SHALL go to ARMED.
REQ-020 The buzzer SHALL be ringing AND blink, where blink is set to 1 on RINGING entry and toggles on each tick_1s while RINGING, giving a 0.5 Hz on/off pattern.
REQ-021 A tick_1s coincident with a state-leaving button SHALL be ignored for the old state's counter.
REQ-022 Editing the alarm while ARMED SHALL not itself cause a trigger unless the match rises after set_en returns to 0.

Reset
REQ-023 On rst_n=0 the block SHALL asynchronously set: state DISARMED, alarm_hour=0, alarm_min=0, all counters 0, blink 0, match_q 1, button history 1.
REQ-024 Therefore armed, ringing, snoozing and buzzer SHALL all be 0 during reset, and no trigger or button edge SHALL occur on the first cycle after release.
REQ-025 A reset asserted during RINGING or SNOOZE SHALL drop buzzer to 0 immediately, without waiting for clk.

Structure
REQ-026 Shared package clock_pkg SHALL hold the alarm state enum, MAX_MIN=59, MAX_HOUR=23 and SEC_PER_MIN=60.
REQ-027 Rising-edge detection SHALL be the sub-module btn_edge, instantiated once per button.
REQ-028 Counters SHALL be sized for the maximum parameter values: ring_cnt 8 bits, snooze_cnt 11 bits.

Verification
REQ-029 The bench SHALL cover edit wrap: DISARMED, set_en=1, pos=0, alarm_min=59, btn_up -> alarm_min=0; then pos=1, hour=0, btn_down -> alarm_hour=23.
REQ-030 The bench SHALL cover trigger: ARMED, alarm 06:30, cur time steps 06:29:59->06:30:00 -> ringing=1 within 2 clk, and buzzer=1 immediately.
REQ-031 The bench SHALL cover timeout: RINGING with RING_TIMEOUT_S=3 and 3 tick_1s pulses -> state ARMED, buzzer=0, with no retrigger while cur_sec stays 0.
REQ-032 The bench SHALL cover snooze: SNOOZE_MIN=1, btn_snooze while ringing -> snoozing=1; after 60 ticks -> ringing=1.
REQ-033 The bench SHALL cover simultaneous buttons: snooze+dismiss on the same cycle -> ARMED; arm+dismiss on the same cycle -> DISARMED.
REQ-034 The bench SHALL cover reset mid-ring: rst_n low while ringing -> all outputs 0 asynchronously, alarm 00:00 after release.
